skywater_dlyline_ctrl: RTL and testbench



---
 rtl/skywater_dlyline_ctrl_if.sv | 15 +
 rtl/skywater_dlyline_ctrl.sv | 67 ++++++
 tb/tb_skywater_dlyline_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/skywater_dlyline_ctrl_if.sv
// skywater_dlyline_ctrl_if: request handshake and delay-line drive bundle for skywater_dlyline_ctrl
interface skywater_dlyline_ctrl_if #(
  parameter int NCELL  = 64,
  parameter int CODE_W = 7
);
  logic              req_valid;
  logic [CODE_W-1:0] req_code;
  logic              req_ready;
  logic [NCELL-1:0]  bk;
  logic [CODE_W-1:0] cur_code;
  logic              busy;
  logic              done;
  modport master (output req_valid, req_code, input req_ready, bk, cur_code, busy, done);
  modport slave  (input req_valid, req_code, output req_ready, bk, cur_code, busy, done);
endinterface

// File: rtl/skywater_dlyline_ctrl.sv
// skywater_dlyline_ctrl: ramps the thermometer bk bus one cell per settle interval toward a requested code
module skywater_dlyline_ctrl #(
  parameter int NCELL     = 64,
  parameter int CODE_W    = 7,
  parameter int STEP_WAIT = 4
) (
  input logic clk,
  input logic rstb,
  skywater_dlyline_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;
  state_t            state, state_n;
  logic [CODE_W-1:0] target, target_n, cur, cur_n, req_clamped;
  logic [NCELL-1:0]  bk, bk_n, one_hot;
  logic [7:0]        cnt, cnt_n;
  logic              done, done_n, decide, up, dn;
  // a step decision is taken on the RAMP edge and on the edge that drains SETTLE
  always_comb begin
    req_clamped = bus.req_code > CODE_W'(NCELL) ? CODE_W'(NCELL) : bus.req_code;
    decide      = state == RAMP || (state == SETTLE && cnt == '0);
    up          = cur < target;
    dn          = cur > target;
    one_hot     = {{(NCELL-1){1'b0}}, 1'b1} << (up ? cur : cur - 1'b1);
    state_n     = state;
    target_n    = target;
    cur_n       = cur;
    bk_n        = bk;
    cnt_n       = cnt;
    done_n      = 1'b0;
    if (state == IDLE && bus.req_valid) begin
      state_n  = RAMP;
      target_n = req_clamped;
    end else if (decide && (up || dn)) begin
      cur_n   = up ? cur + 1'b1 : cur - 1'b1;
      bk_n    = up ? bk | one_hot : bk & ~one_hot;
      cnt_n   = 8'(STEP_WAIT - 1);
      state_n = SETTLE;
    end else if (decide) begin
      state_n = IDLE;
      done_n  = 1'b1;
    end else if (state == SETTLE) begin
      cnt_n = cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state  <= IDLE;
      target <= '0;
      cur    <= '0;
      bk     <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      target <= target_n;
      cur    <= cur_n;
      bk     <= bk_n;
      cnt    <= cnt_n;
      done   <= done_n;
    end
  end
  assign bus.req_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.bk        = bk;
  assign bus.cur_code  = cur;
  assign bus.done      = done;
endmodule

// File: tb/tb_skywater_dlyline_ctrl.sv
// tb_skywater_dlyline_ctrl: two controllers (STEP_WAIT 4 and 1) driven alike and checked against a timing-rule model
module tb_skywater_dlyline_ctrl;
  localparam int NCELL = 64, CODE_W = 7;
  logic clk = 1'b0, rstb = 1'b0, vld = 1'b0;
  logic [CODE_W-1:0] code = '0;
  int sw[2] = '{4, 1};
  int m_cur[2], m_tgt[2], m_n[2], m_k[2];
  bit m_busy[2], m_done[2];
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  skywater_dlyline_ctrl_if #(.NCELL(NCELL), .CODE_W(CODE_W)) b0 (), b1 ();
  assign b0.req_valid = vld;
  assign b0.req_code  = code;
  assign b1.req_valid = vld;
  assign b1.req_code  = code;
  skywater_dlyline_ctrl #(.NCELL(NCELL), .CODE_W(CODE_W), .STEP_WAIT(4)) dut0 (.clk(clk), .rstb(rstb), .bus(b0));
  skywater_dlyline_ctrl #(.NCELL(NCELL), .CODE_W(CODE_W), .STEP_WAIT(1)) dut1 (.clk(clk), .rstb(rstb), .bus(b1));

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] therm(int c);
    logic [63:0] t;
    for (int j = 0; j < 64; j++) t[j] = j < c;
    return t;
  endfunction

  // the model works from the timing rules: steps at E0+1+i*SW, completion at E0+1+n*SW
  task automatic model(int i, logic r, logic v, int c);
    if (!r) begin
      m_cur[i]  = 0;
      m_busy[i] = 0;
      m_done[i] = 0;
    end else begin
      m_done[i] = 0;
      if (m_busy[i]) begin
        m_k[i]++;
        if (m_k[i] - 1 < m_n[i] * sw[i] && (m_k[i] - 1) % sw[i] == 0)
          m_cur[i] += m_tgt[i] > m_cur[i] ? 1 : -1;
        if (m_k[i] == 1 + m_n[i] * sw[i]) begin
          m_busy[i] = 0;
          m_done[i] = 1;
        end
      end else if (v) begin
        m_tgt[i]  = c > NCELL ? NCELL : c;
        m_n[i]    = m_tgt[i] > m_cur[i] ? m_tgt[i] - m_cur[i] : m_cur[i] - m_tgt[i];
        m_k[i]    = 0;
        m_busy[i] = 1;
      end
    end
  endtask

  task automatic cmp(int i, logic [63:0] bk, logic [CODE_W-1:0] cc, logic rdy, logic bsy, logic dn);
    check($sformatf("bk%0d", i), bk, therm(m_cur[i]));
    check($sformatf("cur_code%0d", i), 64'(cc), 64'(m_cur[i]));
    check($sformatf("req_ready%0d", i), 64'(rdy), 64'(!m_busy[i]));
    check($sformatf("busy%0d", i), 64'(bsy), 64'(m_busy[i]));
    check($sformatf("done%0d", i), 64'(dn), 64'(m_done[i]));
  endtask

  task automatic cyc(logic r, logic v, int c);
    @(negedge clk);
    rstb = r;
    vld  = v;
    code = CODE_W'(c);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model(i, r, v, c % 128);
    #1;
    cmp(0, b0.bk, b0.cur_code, b0.req_ready, b0.busy, b0.done);
    cmp(1, b1.bk, b1.cur_code, b1.req_ready, b1.busy, b1.done);
  endtask

  initial begin
    repeat (3) cyc(0, 1, 5);
    cyc(1, 0, 0);
    cyc(1, 1, 5);
    repeat (24) cyc(1, 0, 0);
    cyc(1, 1, 2);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 40);
    repeat (10) cyc(1, 0, 0);
    cyc(1, 1, 70);
    repeat (270) cyc(1, 0, 0);
    cyc(1, 1, 64);
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 1, 10);
    repeat (9) cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 1, 1);
    repeat (8) cyc(1, 0, 0);
    repeat (3000)
      cyc($urandom_range(299) != 0, $urandom_range(5) == 0,
          $urandom_range(1) == 1 ? int'($urandom_range(127)) : int'($urandom_range(64)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
